alu_exec_unit: RTL

//  Parametrised successor to the regA/regB -> ALU -> ALUOUT datapath slice.
//  - Latches operands through a valid/ready handshake and executes one funct3 op.
//  - Shifts run iteratively, 1 bit per cycle.
//  - Holds the result in an internal ALUOUT register until the consumer takes it.
//  - Sits between register-file read and writeback in the multi-cycle core.

---
 rtl/sher_alu_pkg.sv | 20 ++
 rtl/alu_exec_unit_if.sv | 33 +++
 rtl/alu_comb.sv | 45 ++++
 rtl/alu_exec_unit.sv | 116 +++++++++++
 4 files changed

// File: rtl/sher_alu_pkg.sv
// Shared constants and FSM encoding for the
// iterative-shift ALU execution unit.
package sher_alu_pkg;

  localparam logic [2:0] FUNCT3_ADD = 3'd0;
  localparam logic [2:0] FUNCT3_SUB = 3'd1;
  localparam logic [2:0] FUNCT3_OR  = 3'd2;
  localparam logic [2:0] FUNCT3_AND = 3'd3;
  localparam logic [2:0] FUNCT3_XOR = 3'd4;
  localparam logic [2:0] FUNCT3_SLL = 3'd5;
  localparam logic [2:0] FUNCT3_SRL = 3'd6;
  localparam logic [2:0] FUNCT3_SLT = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between
// register-file read and writeback.
interface alu_exec_unit_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       funct3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             eq;
  logic             lt;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, funct3,
    output out_ready,
    input  in_ready, out_valid, result,
    input  eq, lt, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, funct3,
    input  out_ready,
    output in_ready, out_valid, result,
    output eq, lt, busy
  );

endinterface

// File: rtl/alu_comb.sv
// Combinational funct3 ALU with equality and
// configurable signed/unsigned less-than.
module alu_comb
  import sher_alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit CMP_SIGNED = 1'b1
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_res,
  output logic             o_eq,
  output logic             o_lt
);

  logic w_lt;

  generate
    if (CMP_SIGNED) begin : g_signed
      assign w_lt = $signed(i_a) < $signed(i_b);
    end else begin : g_unsigned
      assign w_lt = i_a < i_b;
    end
  endgenerate

  assign o_eq = (i_a == i_b);
  assign o_lt = w_lt;

  // Shift ops are sequenced by the caller.
  always_comb begin
    o_res = i_a;
    unique case (i_op)
      FUNCT3_ADD: o_res = i_a + i_b;
      FUNCT3_SUB: o_res = i_a - i_b;
      FUNCT3_OR:  o_res = i_a | i_b;
      FUNCT3_AND: o_res = i_a & i_b;
      FUNCT3_XOR: o_res = i_a ^ i_b;
      FUNCT3_SLT:
        o_res = {{(WIDTH-1){1'b0}}, w_lt};
      default:    o_res = i_a;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU stage: latches operands, runs one
// op (shifts 1 bit/cycle), holds ALUOUT until taken.
module alu_exec_unit
  import sher_alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit CMP_SIGNED = 1'b1
) (
  input logic         clk,
  input logic         reset,
  alu_exec_unit_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_op;
  logic [SHW-1:0]   r_cnt;
  logic             r_sh_zero;
  logic             r_eq;
  logic             r_lt;

  logic             w_accept;
  logic             w_is_shift;
  logic             w_last;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH-1:0] w_sh_next;
  logic [WIDTH-1:0] w_alu;
  logic             w_eq;
  logic             w_lt;

  alu_comb #(
    .WIDTH      (WIDTH),
    .CMP_SIGNED (CMP_SIGNED)
  ) u_alu (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_op  (r_op),
    .o_res (w_alu),
    .o_eq  (w_eq),
    .o_lt  (w_lt)
  );

  assign w_amt = bus.in_b[SHW-1:0];
  assign w_accept =
    (r_state == IDLE) && bus.in_valid;
  assign w_is_shift =
    (r_op == FUNCT3_SLL) || (r_op == FUNCT3_SRL);
  assign w_last =
    !w_is_shift || (r_cnt == SHW'(1));

  // r_sh is a working copy so eq/lt see r_a unshifted.
  assign w_sh_next =
    r_sh_zero            ? r_sh :
    (r_op == FUNCT3_SLL) ? (r_sh << 1) :
                           (r_sh >> 1);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid) w_next = EXEC;
      EXEC:    if (w_last) w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sh      <= '0;
      r_res     <= '0;
      r_op      <= '0;
      r_cnt     <= '0;
      r_sh_zero <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
    end else if (w_accept) begin
      r_a       <= bus.in_a;
      r_b       <= bus.in_b;
      r_sh      <= bus.in_a;
      r_op      <= bus.funct3;
      r_sh_zero <= (w_amt == '0);
      r_cnt     <= (w_amt == '0) ? SHW'(1) : w_amt;
    end else if (r_state == EXEC) begin
      if (w_is_shift) begin
        r_sh  <= w_sh_next;
        r_cnt <= r_cnt - SHW'(1);
      end
      if (w_last) begin
        r_res <= w_is_shift ? w_sh_next : w_alu;
        r_eq  <= w_eq;
        r_lt  <= w_lt;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == EXEC);
  assign bus.result    = r_res;
  assign bus.eq        = r_eq;
  assign bus.lt        = r_lt;

endmodule
